miriscv_data_arbiter: RTL

Shares the single data port of miriscv_ram between two masters: m0 (miriscv_core load/store unit) and m1 (program loader / DMA engine).
- Arbitrates with round-robin and supports a bounded m1 lock for bursts.
- Decodes out-of-range addresses to an error response instead of a RAM access.
- Returns a registered, one-cycle-latency response to the granted master.
- Sits between the masters and the RAM data port in miriscv_top, replacing the ad-hoc range-check gating.

---
 rtl/miriscv_data_arbiter_pkg.sv | 33 +++
 rtl/miriscv_rr_arbiter2.sv | 39 +++
 rtl/miriscv_data_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_data_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_arb_pkg
// Shared types and constants for the miriscv data-port arbiter:
//   - master identifiers (M0 = core LSU, M1 = loader / DMA)
//   - arbiter FSM states
//   - port widths and the lock-counter width
//   - address range helper used by the arbiter's error decode
// -----------------------------------------------------------------------------
package miriscv_arb_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BE_W       = 4;
   localparam int LOCK_CNT_W = 8;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_e;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK  = 2'd1,
      FORCE = 2'd2
   } arb_state_e;

   // Unsigned compare: anything at or above the RAM size is an error access.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] ram_size);
      return (addr < ram_size);
   endfunction

endpackage

// File: rtl/miriscv_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// miriscv_rr_arbiter2
// Two-way round-robin picker. Purely combinational.
//   req_i  [1:0] : raw requests, bit index = master id
//   ptr_i        : master preferred when both (unmasked) requests are present
//   mask_i [1:0] : per-master enable driven by the owning FSM
//   gnt_o  [1:0] : one-hot grant (or zero when nothing eligible)
// -----------------------------------------------------------------------------
module miriscv_rr_arbiter2
   import miriscv_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  master_id_e ptr_i,
   input  logic [1:0] mask_i,
   output logic [1:0] gnt_o
);

   logic [1:0] eligible_s;

   assign eligible_s = req_i & mask_i;

   // Pick the single eligible master, or the preferred one on contention.
   always_comb begin
      gnt_o = 2'b00;
      case (eligible_s)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11: begin
            if (ptr_i == M1) begin
               gnt_o = 2'b10;
            end else begin
               gnt_o = 2'b01;
            end
         end
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// -----------------------------------------------------------------------------
// miriscv_data_arbiter
// Shares the miriscv_ram data port between m0 (core LSU) and m1 (loader/DMA).
//   clk_i / rst_i        : clock, asynchronous active-high reset
//   mX_req/we/be/addr/wdata_i : master request channels
//   m1_lock_i            : m1 wants to keep the port after its grant (bounded)
//   mX_gnt_o             : combinational accept
//   mX_rvalid_o/mX_err_o : registered one-cycle-latency response
//   m_rdata_o            : shared registered read data
//   ram_*                : RAM data port (ram_rdata_i is same-cycle)
// Out-of-range addresses are granted but never reach the RAM; they return err.
// -----------------------------------------------------------------------------
module miriscv_data_arbiter
   import miriscv_arb_pkg::*;
#(
   parameter int unsigned RAM_SIZE = 256,
   parameter int unsigned MAX_LOCK = 16
)
(
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [BE_W-1:0]   m0_be_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,

   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [BE_W-1:0]   m1_be_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   input  logic              m1_lock_i,

   output logic              m0_gnt_o,
   output logic              m1_gnt_o,
   output logic              m0_rvalid_o,
   output logic              m1_rvalid_o,
   output logic              m0_err_o,
   output logic              m1_err_o,
   output logic [DATA_W-1:0] m_rdata_o,

   output logic              ram_req_o,
   output logic              ram_we_o,
   output logic [BE_W-1:0]   ram_be_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   localparam logic [ADDR_W-1:0]     RAM_SIZE_C = ADDR_W'(RAM_SIZE);
   localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

   arb_state_e              state_q,    state_d;
   master_id_e              ptr_q,      ptr_d;
   logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [1:0]              rvalid_q,   rvalid_d;
   logic [1:0]              err_q,      err_d;
   logic [DATA_W-1:0]       rdata_q,    rdata_d;

   logic [1:0]              req_s;
   logic [1:0]              mask_s;
   logic [1:0]              gnt_s;
   logic                    any_gnt_s;
   logic                    sel_we_s;
   logic [BE_W-1:0]         sel_be_s;
   logic [ADDR_W-1:0]       sel_addr_s;
   logic [DATA_W-1:0]       sel_wdata_s;
   logic                    in_range_s;
   logic [LOCK_CNT_W-1:0]   lock_cnt_inc_s;

   assign req_s          = {m1_req_i, m0_req_i};
   assign any_gnt_s      = |gnt_s;
   assign lock_cnt_inc_s = lock_cnt_q + 8'd1;

   // Per-state eligibility: LOCK admits only m1, FORCE only m0.
   always_comb begin
      mask_s = 2'b11;
      case (state_q)
         ARB:     mask_s = 2'b11;
         LOCK:    mask_s = 2'b10;
         FORCE:   mask_s = 2'b01;
         default: mask_s = 2'b11;
      endcase
   end

   miriscv_rr_arbiter2 u_rr (
      .req_i  (req_s),
      .ptr_i  (ptr_q),
      .mask_i (mask_s),
      .gnt_o  (gnt_s)
   );

   assign m0_gnt_o = gnt_s[0];
   assign m1_gnt_o = gnt_s[1];

   // RAM-port mux: m1 only when m1 is granted, m0 otherwise (including idle).
   always_comb begin
      if (gnt_s[1]) begin
         sel_we_s    = m1_we_i;
         sel_be_s    = m1_be_i;
         sel_addr_s  = m1_addr_i;
         sel_wdata_s = m1_wdata_i;
      end else begin
         sel_we_s    = m0_we_i;
         sel_be_s    = m0_be_i;
         sel_addr_s  = m0_addr_i;
         sel_wdata_s = m0_wdata_i;
      end
   end

   assign in_range_s  = addr_in_range(sel_addr_s, RAM_SIZE_C);
   assign ram_req_o   = any_gnt_s & in_range_s;
   assign ram_we_o    = sel_we_s;
   assign ram_be_o    = sel_be_s;
   assign ram_addr_o  = sel_addr_s;
   assign ram_wdata_o = sel_wdata_s;

   // Arbitration FSM next state, round-robin pointer and lock counter.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      // The master not granted last is preferred next time.
      if (gnt_s[0]) begin
         ptr_d = M1;
      end else if (gnt_s[1]) begin
         ptr_d = M0;
      end else begin
         ptr_d = ptr_q;
      end

      case (state_q)
         ARB: begin
            if (gnt_s[1] && m1_lock_i) begin
               lock_cnt_d = 8'd1;
               // A bound of one means the first grant already uses it up.
               if (MAX_LOCK_C <= 8'd1) begin
                  state_d = FORCE;
               end else begin
                  state_d = LOCK;
               end
            end else begin
               state_d    = ARB;
               lock_cnt_d = 8'd0;
            end
         end
         LOCK: begin
            if (!m1_lock_i) begin
               state_d    = ARB;
               ptr_d      = M0;
               lock_cnt_d = 8'd0;
            end else if (lock_cnt_inc_s >= MAX_LOCK_C) begin
               state_d    = FORCE;
               lock_cnt_d = lock_cnt_inc_s;
            end else begin
               state_d    = LOCK;
               lock_cnt_d = lock_cnt_inc_s;
            end
         end
         FORCE: begin
            state_d    = ARB;
            lock_cnt_d = 8'd0;
            // If m0 used the forced slot it was granted last, so m1 is
            // preferred next; an unused slot leaves m0 preferred.
            if (gnt_s[0]) begin
               ptr_d = M1;
            end else begin
               ptr_d = M0;
            end
         end
         default: begin
            state_d    = ARB;
            ptr_d      = M0;
            lock_cnt_d = 8'd0;
         end
      endcase
   end

   // Response for this cycle's grant, presented on the next cycle.
   always_comb begin
      rvalid_d = gnt_s;
      err_d    = gnt_s & {2{~in_range_s}};
      if (any_gnt_s && in_range_s && !sel_we_s) begin
         rdata_d = ram_rdata_i;
      end else begin
         rdata_d = 32'd0;
      end
   end

   // State and response registers; reset drops any pending response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ARB;
         ptr_q      <= M0;
         lock_cnt_q <= 8'd0;
         rvalid_q   <= 2'b00;
         err_q      <= 2'b00;
         rdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign m0_rvalid_o = rvalid_q[0];
   assign m1_rvalid_o = rvalid_q[1];
   assign m0_err_o    = err_q[0];
   assign m1_err_o    = err_q[1];
   assign m_rdata_o   = rdata_q;

endmodule
